// File: rtl/sync_fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_level
// Purpose  : First-word-fall-through synchronous FIFO with occupancy count,
//            almost-full/almost-empty watermarks and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_level #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 2**DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             WVALID,
    output logic             WREADY,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    input  logic             RREADY,
    output logic [DEPTH:0]   LEVEL,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY
);

    localparam int             CAP     = 2**DEPTH;
    localparam logic [DEPTH:0] CAP_CNT = (DEPTH+1)'(CAP);
    localparam logic [DEPTH:0] AF_TH   = (DEPTH+1)'(AF_LEVEL);
    localparam logic [DEPTH:0] AE_TH   = (DEPTH+1)'(AE_LEVEL);
    localparam logic [DEPTH:0] ONE     = (DEPTH+1)'(1);

    logic [WIDTH-1:0] mem [CAP];
    logic [DEPTH:0]   wp;
    logic [DEPTH:0]   rp;
    logic [DEPTH:0]   lvl_n;
    logic [DEPTH:0]   lvl_d;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = WVALID & WREADY;
    assign rd_fire = RVALID & RREADY;

    // Flush overrides any handshake in the same cycle, so the flags load as if empty.
    always_comb begin
        lvl_n = LEVEL;
        if (wr_fire) begin
            lvl_n = lvl_n + ONE;
        end
        if (rd_fire) begin
            lvl_n = lvl_n - ONE;
        end
        lvl_d = FLUSH ? '0 : lvl_n;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wp           <= '0;
            rp           <= '0;
            LEVEL        <= '0;
            WREADY       <= 1'b0;
            RVALID       <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            if (FLUSH) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_fire) begin
                    wp <= wp + ONE;
                end
                if (rd_fire) begin
                    rp <= rp + ONE;
                end
            end
            LEVEL        <= lvl_d;
            WREADY       <= (lvl_d != CAP_CNT);
            RVALID       <= (lvl_d != '0);
            ALMOST_FULL  <= (lvl_d >= AF_TH);
            ALMOST_EMPTY <= (lvl_d <= AE_TH);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_fire && !FLUSH) begin
            mem[wp[DEPTH-1:0]] <= WDATA;
        end
    end

    assign RDATA = RVALID ? mem[rp[DEPTH-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_level
// Purpose  : Directed and random checks of sync_fifo_level against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_level;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CAP   = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             FLUSH;
    logic [WIDTH-1:0] WDATA;
    logic             WVALID;
    logic             WREADY;
    logic [WIDTH-1:0] RDATA;
    logic             RVALID;
    logic             RREADY;
    logic [DEPTH:0]   LEVEL;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q[$];
    bit               no_edge_since_reset;

    sync_fifo_level #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit exp_wready();
        return !no_edge_since_reset && (q.size() != CAP);
    endfunction

    task automatic check_all();
        logic [DEPTH:0] diff;
        int n;
        n    = q.size();
        diff = dut.wp - dut.rp;
        chk("level",        32'(LEVEL),        n);
        chk("wready",       32'(WREADY),       32'(exp_wready()));
        chk("rvalid",       32'(RVALID),       32'(n != 0));
        chk("rdata",        32'(RDATA),        (n != 0) ? 32'(q[0]) : 32'd0);
        chk("almost_full",  32'(ALMOST_FULL),  32'(n >= AF));
        chk("almost_empty", 32'(ALMOST_EMPTY), 32'(n <= AE));
        chk("ptr_diff",     32'(diff),         n);
        chk("ptr_full",  32'((dut.wp[DEPTH-1:0] == dut.rp[DEPTH-1:0]) && (dut.wp[DEPTH] != dut.rp[DEPTH])),
            32'(n == CAP));
        chk("ptr_empty", 32'(dut.wp == dut.rp), 32'(n == 0));
    endtask

    // One clock: decide which handshakes fire from the model, advance, then compare.
    task automatic step();
        bit wf;
        bit rf;
        wf = WVALID && exp_wready();
        rf = RREADY && (q.size() != 0);
        @(posedge CLK);
        if (FLUSH) begin
            q.delete();
        end else begin
            if (rf) void'(q.pop_front());
            if (wf) q.push_back(WDATA);
        end
        no_edge_since_reset = 1'b0;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        no_edge_since_reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_rd [4];
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;

        RESET = 1'b1; FLUSH = 1'b0; WDATA = '0; WVALID = 1'b0; RREADY = 1'b0;
        model_reset();
        #12;
        check_all();
        RESET = 1'b0;
        #1;
        chk("wready_before_edge", 32'(WREADY), 32'd0);
        step();
        chk("wready_after_release", 32'(WREADY), 32'd1);

        // Fill to capacity with the read side stalled.
        WVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WDATA = exp_rd[i];
            step();
            chk("fill_level", 32'(LEVEL), i + 1);
            if (i == 1) chk("ae_after_2nd", 32'(ALMOST_EMPTY), 32'd0);
            if (i == 2) chk("af_after_3rd", 32'(ALMOST_FULL), 32'd1);
        end
        chk("wready_full", 32'(WREADY), 32'd0);
        WDATA = 8'h55;
        for (int i = 0; i < 3; i++) step();
        chk("no_write_when_full", 32'(LEVEL), 32'd4);

        // Drain in order.
        WVALID = 1'b0;
        RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(RDATA), 32'(exp_rd[i]));
            step();
            if (i == 0) chk("wready_after_1st_read", 32'(WREADY), 32'd1);
        end
        chk("drained_rvalid", 32'(RVALID), 32'd0);
        chk("drained_rdata",  32'(RDATA),  32'd0);

        // Hold two entries while streaming; pointers wrap repeatedly.
        RREADY = 1'b0;
        WVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            WDATA = 8'(i);
            step();
        end
        RREADY = 1'b1;
        for (int i = 2; i < 22; i++) begin
            WDATA = 8'(i);
            chk("stream_head", 32'(RDATA), i - 2);
            step();
            chk("stream_level", 32'(LEVEL), 32'd2);
        end
        WVALID = 1'b0;
        step();
        step();

        // Full with both sides requesting: only the read fires.
        RREADY = 1'b0;
        WVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WDATA = 8'h60 + 8'(i);
            step();
        end
        WDATA  = 8'h70;
        RREADY = 1'b1;
        step();
        chk("full_rw_level", 32'(LEVEL), 32'd3);
        RREADY = 1'b0;
        step();
        chk("full_rw_next_write", 32'(LEVEL), 32'd4);

        // Flush at level 3 with concurrent handshakes.
        WVALID = 1'b0;
        RREADY = 1'b1;
        step();
        FLUSH  = 1'b1;
        WVALID = 1'b1;
        WDATA  = 8'hEE;
        step();
        chk("flush_level",  32'(LEVEL),        32'd0);
        chk("flush_rvalid", 32'(RVALID),       32'd0);
        chk("flush_wready", 32'(WREADY),       32'd1);
        chk("flush_ae",     32'(ALMOST_EMPTY), 32'd1);
        FLUSH  = 1'b0;
        RREADY = 1'b0;
        WDATA  = 8'hA5;
        step();
        WVALID = 1'b0;
        chk("flush_first_word", 32'(RDATA), 32'hA5);

        // Asynchronous reset mid-cycle at level 2.
        WVALID = 1'b1;
        WDATA  = 8'h5A;
        step();
        WVALID = 1'b0;
        chk("pre_reset_level", 32'(LEVEL), 32'd2);
        #3;
        RESET = 1'b1;
        model_reset();
        #1;
        check_all();
        #10;
        check_all();
        RESET = 1'b0;
        #1;
        chk("wready_held_low", 32'(WREADY), 32'd0);
        step();
        chk("wready_after_reset", 32'(WREADY), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            WVALID = 1'($urandom_range(0, 1));
            RREADY = 1'($urandom_range(0, 1));
            FLUSH  = ($urandom_range(0, 31) == 0);
            WDATA  = 8'($urandom);
            step();
        end
        FLUSH  = 1'b0;
        WVALID = 1'b0;
        RREADY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
